h_chan_arb: RTL and testbench
=============================

// Module: h_chan_arb
//
// PURPOSE
//  N-channel ingress buffer plus round-robin arbiter merging N valid/ready streams onto one.
//  Each channel owns a DEPTH-entry FIFO. A registered output stage presents one beat per
//  cycle, tagged with its source channel. An optional packet mode holds the grant until a
//  beat with last=1 is taken. Instanced inside top-level h between ingress ports and core.
//
// PARAMETERS
//  N_CH      4   number of input channels (>=2)
//  W         32  data width in bits
//  DEPTH     4   entries per channel FIFO (power of 2, >=2)
//  PKT_MODE  0   0: grant re-arbitrated every beat; 1: grant held until a last=1 beat is taken
//
// PORTS
//  clk       in   1                  clock, all state rises on posedge
//  arst      in   1                  async reset, active-high
//  in_vld    in   N_CH               per-channel beat valid
//  in_dat    in   N_CH x W           per-channel beat data
//  in_last   in   N_CH               per-channel end-of-packet marker
//  in_rdy    out  N_CH               per-channel accept (FIFO not full)
//  out_vld   out  1                  output beat valid
//  out_dat   out  W                  output beat data
//  out_last  out  1                  output end-of-packet marker
//  out_ch    out  $clog2(N_CH)       source channel of the output beat
//  out_rdy   in   1                  downstream accept
//  occ       out  N_CH x $clog2(DEPTH+1)  per-channel FIFO occupancy
//
// BEHAVIOUR
//  - Reset (async assert, sync release): FIFOs empty; occ=0; in_rdy all 1.
//    out_vld=0, out_dat=0, out_last=0, out_ch=0. RR pointer = N_CH-1, so ch0 wins first.
//    Packet lock is cleared.
//  - Reset mid-operation discards all buffered and in-flight beats. No partial packet
//    survives reset.
//  - Push: in_vld[i] & in_rdy[i]. in_rdy[i] = !full[i], taken from registered state only.
//    There is no combinational path from out_rdy to in_rdy.
//  - When FIFO i is full, no push happens that cycle, even if i is popped in the same cycle.
//  - Advance: adv = !out_vld | out_rdy. Only on adv is a new beat loaded into the output
//    register, popping the granted FIFO.
//  - If adv is set and no FIFO is eligible, out_vld <= 0.
//  - While out_vld & !out_rdy, out_dat, out_last and out_ch are held stable.
//  - Arbitration: grant = first non-empty channel strictly after the RR pointer, cyclic
//    wrap N_CH-1 -> 0. The pointer updates to the granted channel on each pop.
//  - PKT_MODE=1: after popping a last=0 beat from ch g, lock to g. Only g is eligible
//    until its last=1 beat is popped, even if g is momentarily empty; then unlock.
//    PKT_MODE=0 ignores in_last for arbitration and passes it through.
//  - Latency: a beat pushed into empty FIFO i at edge t, with i granted and adv=1, shows
//    out_vld=1 in the cycle after edge t+1. Minimum latency is 2 cycles.
//  - Throughput: 1 beat/cycle sustained with out_rdy=1.
//  - Per-FIFO push and pop in the same cycle leaves occ unchanged.
//  - Pointer widths are $clog2(DEPTH) and wrap naturally. Occupancy is a separate counter.
//  - occ[i] is registered and reflects the state after the previous edge.
//
// STRUCTURE
//  - h_pkg: ch_t (logic [$clog2(N_CH)-1:0]) and the beat struct {dat, last}.
//    Also a generic rr-select function (first set bit after the pointer, cyclic).
//  - Sub-module h_fifo: parametrised W+1 x DEPTH sync FIFO with push, pop, full, empty and
//    occ. Generated N_CH times.
//  - Arbiter, lock and output register stay in h_chan_arb.
//
// TESTING
//  1. Reset: assert arst mid-stream -> next cycle out_vld=0, all occ=0, in_rdy=4'b1111.
//     First grant after release is ch0.
//  2. Single beat: push 0xDEAD_BEEF on ch2 at edge t, out_rdy=1 -> out_vld at t+2,
//     out_dat=0xDEADBEEF, out_ch=2.
//  3. RR fairness: all 4 channels hold 4 beats, out_rdy=1 -> out_ch sequence 0,1,2,3 x4,
//     16 beats in 16 cycles.
//  4. Backpressure/full: out_rdy=0, push 5 beats on ch1 -> in_rdy[1]=0 after 4, occ[1]=4,
//     output held stable.
//  5. PKT_MODE=1: ch0 3-beat packet and ch1 1-beat packet, both pending ->
//     out_ch 0,0,0 then 1; ch0 gaps do not let ch1 in.
//  6. Random stress: random vld/rdy on all channels -> per-channel order preserved, no loss
//     or duplication, in_rdy never depends on out_rdy.

Source files
------------

// File: rtl/h_pkg.sv
// Shared types and helpers for the channel arbiter slice.
package h_pkg;

  localparam int N_CH_DEF = 4;
  localparam int W_DEF    = 32;
  // Widest request vector rr_select can scan; N_CH must not exceed this.
  localparam int MAX_CH   = 32;

  typedef logic [$clog2(N_CH_DEF)-1:0] ch_t;

  typedef struct packed {
    logic [W_DEF-1:0] dat;
    logic             last;
  } beat_t;

  // First set bit of req strictly after ptr, wrapping n-1 -> 0. Returns -1 if none.
  // Scans from the farthest candidate down so the closest one is written last.
  function automatic int rr_select(input logic [MAX_CH-1:0] req, input int ptr, input int n);
    int sel;
    int idx;
    sel = -1;
    for (int k = MAX_CH; k >= 1; k--) begin
      if (k <= n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx[$clog2(MAX_CH)-1:0]]) sel = idx;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/h_fifo.sv
// Per-channel synchronous FIFO with fall-through head (read is combinational from
// the storage array so the output stage can load a beat the edge after it is pushed).
module h_fifo #(
  parameter int DW    = 33,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         i_push,
  input  logic [DW-1:0]                i_din,
  input  logic                         i_pop,
  output logic [DW-1:0]                o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [OW-1:0] r_occ;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_occ == OW'(DEPTH));
  assign o_empty   = (r_occ == '0);
  // A full FIFO refuses the push even when it is popped in the same cycle.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_occ     = r_occ;

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally at DEPTH (power of two); occupancy counted separately.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/h_chan_arb.sv
// N-channel ingress buffering with round-robin merge onto one registered output
// stream. Optional packet mode keeps the grant on one channel until its last beat.
module h_chan_arb
  import h_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int W        = 32,
  parameter int DEPTH    = 4,
  parameter int PKT_MODE = 0
) (
  input  logic                                    clk,
  input  logic                                    arst,
  input  logic [N_CH-1:0]                         in_vld,
  input  logic [N_CH-1:0][W-1:0]                  in_dat,
  input  logic [N_CH-1:0]                         in_last,
  output logic [N_CH-1:0]                         in_rdy,
  output logic                                    out_vld,
  output logic [W-1:0]                            out_dat,
  output logic                                    out_last,
  output logic [$clog2(N_CH)-1:0]                 out_ch,
  input  logic                                    out_rdy,
  output logic [N_CH-1:0][$clog2(DEPTH+1)-1:0]    occ
);

  localparam int CW = $clog2(N_CH);

  logic [N_CH-1:0]   w_full;
  logic [N_CH-1:0]   w_empty;
  logic [N_CH-1:0]   w_pop;
  logic [N_CH-1:0]   w_req;
  logic [MAX_CH-1:0] w_req_ext;
  logic [W:0]        w_head [N_CH];
  logic [W:0]        w_beat;
  logic              w_adv;
  logic              w_gnt_vld;
  logic [CW-1:0]     w_gnt;
  int                w_sel;

  logic              r_out_vld;
  logic [W-1:0]      r_out_dat;
  logic              r_out_last;
  logic [CW-1:0]     r_out_ch;
  logic [CW-1:0]     r_ptr;
  logic              r_lock;
  logic [CW-1:0]     r_lock_ch;

  // The output stage may take a new beat when it is empty or being drained.
  assign w_adv = ~r_out_vld | out_rdy;

  // in_rdy comes only from FIFO state, never from out_rdy.
  assign in_rdy = ~w_full;

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_fifo
      h_fifo #(
        .DW    (W + 1),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .arst    (arst),
        .i_push  (in_vld[gi]),
        .i_din   ({in_dat[gi], in_last[gi]}),
        .i_pop   (w_pop[gi]),
        .o_dout  (w_head[gi]),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi]),
        .o_occ   (occ[gi])
      );
      assign w_pop[gi] = w_adv & w_gnt_vld & (w_gnt == CW'(gi));
    end
  endgenerate

  // Eligibility (lock restricts to one channel, even while it is empty) and RR pick.
  always_comb begin
    w_req = ~w_empty;
    if ((PKT_MODE != 0) && r_lock) begin
      w_req            = '0;
      w_req[r_lock_ch] = ~w_empty[r_lock_ch];
    end
    w_req_ext             = '0;
    w_req_ext[N_CH-1:0]   = w_req;
    w_sel                 = rr_select(w_req_ext, int'(r_ptr), N_CH);
    w_gnt_vld             = (w_sel >= 0);
    w_gnt                 = w_sel[CW-1:0];
    w_beat                = w_head[w_gnt];
  end

  // Output register, RR pointer and packet lock all move only on advance.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_out_vld  <= 1'b0;
      r_out_dat  <= '0;
      r_out_last <= 1'b0;
      r_out_ch   <= '0;
      r_ptr      <= CW'(N_CH - 1);
      r_lock     <= 1'b0;
      r_lock_ch  <= '0;
    end else if (w_adv) begin
      if (w_gnt_vld) begin
        r_out_vld  <= 1'b1;
        r_out_dat  <= w_beat[W:1];
        r_out_last <= w_beat[0];
        r_out_ch   <= w_gnt;
        r_ptr      <= w_gnt;
        if (PKT_MODE != 0) begin
          r_lock    <= ~w_beat[0];
          r_lock_ch <= w_gnt;
        end
      end else begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign out_vld  = r_out_vld;
  assign out_dat  = r_out_dat;
  assign out_last = r_out_last;
  assign out_ch   = r_out_ch;

endmodule

// File: tb/tb_h_chan_arb.sv
// Bench for h_chan_arb: one instance per arbitration mode, a queue-based reference
// model checked every cycle, a directed vector table and a few hand sequences.
`timescale 1ns/1ps
module tb_h_chan_arb;

  localparam int DEP = 4;

  logic clk = 1'b0;
  logic arst = 1'b0;

  logic [3:0]        in_vld  [2];
  logic [3:0][31:0]  in_dat  [2];
  logic [3:0]        in_last [2];
  logic [3:0]        in_rdy  [2];
  logic              out_vld [2];
  logic [31:0]       out_dat [2];
  logic              out_last[2];
  logic [1:0]        out_ch  [2];
  logic              out_rdy [2];
  logic [3:0][2:0]   occ     [2];

  always #5 clk = ~clk;

  h_chan_arb #(.N_CH(4), .W(32), .DEPTH(DEP), .PKT_MODE(0)) dut0 (
    .clk(clk), .arst(arst), .in_vld(in_vld[0]), .in_dat(in_dat[0]), .in_last(in_last[0]),
    .in_rdy(in_rdy[0]), .out_vld(out_vld[0]), .out_dat(out_dat[0]), .out_last(out_last[0]),
    .out_ch(out_ch[0]), .out_rdy(out_rdy[0]), .occ(occ[0]));

  h_chan_arb #(.N_CH(4), .W(32), .DEPTH(DEP), .PKT_MODE(1)) dut1 (
    .clk(clk), .arst(arst), .in_vld(in_vld[1]), .in_dat(in_dat[1]), .in_last(in_last[1]),
    .in_rdy(in_rdy[1]), .out_vld(out_vld[1]), .out_dat(out_dat[1]), .out_last(out_last[1]),
    .out_ch(out_ch[1]), .out_rdy(out_rdy[1]), .occ(occ[1]));

  // Reference model: per-channel queues of {dat,last}, plus the presented beat.
  logic [32:0] mq [8][$];
  logic        m_vld [2];
  logic [31:0] m_dat [2];
  logic        m_last[2];
  int          m_ch  [2];
  int          m_ptr [2];
  logic        m_lock[2];
  int          m_lock_ch[2];

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          inst;
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [3:0]  last;
    logic        rdy;
    logic        e_vld;
    logic [1:0]  e_ch;
    logic [31:0] e_dat;
    logic        e_last;
    logic [3:0]  e_in_rdy;
    int          occ_ch;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s #%0d act=%0h exp=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_vld[m] = 1'b0; m_dat[m] = '0; m_last[m] = 1'b0; m_ch[m] = 0;
      m_ptr[m] = 3; m_lock[m] = 1'b0; m_lock_ch[m] = 0;
    end
    for (int q = 0; q < 8; q++) mq[q].delete();
  endtask

  // One clock edge of the behaviour: pick from pre-edge contents, then accept pushes
  // into any queue that was not full before the edge.
  task automatic model_step(input int m);
    bit          adv;
    int          pick;
    int          sz[4];
    logic [32:0] b;
    adv = !m_vld[m] || out_rdy[m];
    for (int c = 0; c < 4; c++) sz[c] = mq[m*4+c].size();
    if (adv) begin
      pick = -1;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_ptr[m] + k) % 4;
        if (pick < 0 && sz[c] > 0 && (!m_lock[m] || c == m_lock_ch[m])) pick = c;
      end
      if (pick >= 0) begin
        b = mq[m*4+pick].pop_front();
        m_vld[m] = 1'b1; m_dat[m] = b[32:1]; m_last[m] = b[0];
        m_ch[m] = pick; m_ptr[m] = pick;
        if (m == 1) begin
          m_lock[m] = !b[0];
          m_lock_ch[m] = pick;
        end
      end else begin
        m_vld[m] = 1'b0;
      end
    end
    for (int c = 0; c < 4; c++)
      if (in_vld[m][c] && sz[c] < DEP) mq[m*4+c].push_back({in_dat[m][c], in_last[m][c]});
  endtask

  function automatic logic [3:0] model_rdy(input int m);
    logic [3:0] r;
    for (int c = 0; c < 4; c++) r[c] = (mq[m*4+c].size() < DEP);
    return r;
  endfunction

  task automatic model_cmp(input int m);
    chk("m_out_vld", m, out_vld[m], m_vld[m]);
    if (m_vld[m]) begin
      chk("m_out_dat", m, out_dat[m], m_dat[m]);
      chk("m_out_last", m, out_last[m], m_last[m]);
      chk("m_out_ch", m, out_ch[m], m_ch[m]);
    end
    for (int c = 0; c < 4; c++)
      chk($sformatf("m_occ%0d", c), m, occ[m][c], mq[m*4+c].size());
    chk("m_in_rdy", m, in_rdy[m], model_rdy(m));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    model_cmp(0);
    model_cmp(1);
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      in_vld[m] = '0; in_dat[m] = '0; in_last[m] = '0; out_rdy[m] = 1'b1;
    end
  endtask

  // Asserts reset away from the clock edge, checks cleared state, releases after an edge.
  task automatic do_reset_check();
    arst = 1'b1;
    #1;
    model_reset();
    for (int m = 0; m < 2; m++) begin
      chk("rst_out_vld", m, out_vld[m], 0);
      chk("rst_out_dat", m, out_dat[m], 0);
      chk("rst_out_last", m, out_last[m], 0);
      chk("rst_out_ch", m, out_ch[m], 0);
      chk("rst_occ", m, occ[m], 0);
      chk("rst_in_rdy", m, in_rdy[m], 4'hF);
    end
    @(posedge clk);
    #1;
    arst = 1'b0;
  endtask

  function automatic vec_t v(int inst, logic [3:0] vld, logic [31:0] dat, logic [3:0] last,
                             logic rdy, logic ev, logic [1:0] ech, logic [31:0] ed, logic el,
                             logic [3:0] er, int oc, logic [2:0] eo);
    vec_t r;
    r = '{inst, vld, dat, last, rdy, ev, ech, ed, el, er, oc, eo};
    return r;
  endfunction

  initial begin
    // Single beat on ch2, then ch1 filled under backpressure (PKT_MODE=0 instance).
    tbl[0]  = v(0, 4'b0100, 32'hDEADBEEF, 4'b0, 1, 0, 0, 32'h0,        0, 4'hF, 2, 1);
    tbl[1]  = v(0, 4'b0000, 32'h0,        4'b0, 1, 1, 2, 32'hDEADBEEF, 0, 4'hF, 2, 0);
    tbl[2]  = v(0, 4'b0000, 32'h0,        4'b0, 1, 0, 0, 32'h0,        0, 4'hF, 2, 0);
    tbl[3]  = v(0, 4'b0010, 32'h100,      4'b0, 0, 0, 0, 32'h0,        0, 4'hF, 1, 1);
    tbl[4]  = v(0, 4'b0010, 32'h101,      4'b0, 0, 1, 1, 32'h100,      0, 4'hF, 1, 1);
    tbl[5]  = v(0, 4'b0010, 32'h102,      4'b0, 0, 1, 1, 32'h100,      0, 4'hF, 1, 2);
    tbl[6]  = v(0, 4'b0010, 32'h103,      4'b0, 0, 1, 1, 32'h100,      0, 4'hF, 1, 3);
    tbl[7]  = v(0, 4'b0010, 32'h104,      4'b0, 0, 1, 1, 32'h100,      0, 4'hD, 1, 4);
    tbl[8]  = v(0, 4'b0010, 32'h105,      4'b0, 0, 1, 1, 32'h100,      0, 4'hD, 1, 4);
    tbl[9]  = v(0, 4'b0000, 32'h0,        4'b0, 1, 1, 1, 32'h101,      0, 4'hF, 1, 3);
    tbl[10] = v(0, 4'b0000, 32'h0,        4'b0, 1, 1, 1, 32'h102,      0, 4'hF, 1, 2);
    tbl[11] = v(0, 4'b0000, 32'h0,        4'b0, 1, 1, 1, 32'h103,      0, 4'hF, 1, 1);
    tbl[12] = v(0, 4'b0000, 32'h0,        4'b0, 1, 1, 1, 32'h104,      0, 4'hF, 1, 0);
    tbl[13] = v(0, 4'b0000, 32'h0,        4'b0, 1, 0, 0, 32'h0,        0, 4'hF, 1, 0);
    // Packet mode: ch0 3-beat packet with a gap, ch1 single-beat packet waits.
    tbl[14] = v(1, 4'b0011, 32'hA0,       4'b0010, 1, 0, 0, 32'h0,     0, 4'hF, 0, 1);
    tbl[15] = v(1, 4'b0000, 32'h0,        4'b0, 1, 1, 0, 32'hA0,       0, 4'hF, 1, 1);
    tbl[16] = v(1, 4'b0000, 32'h0,        4'b0, 1, 0, 0, 32'h0,        0, 4'hF, 1, 1);
    tbl[17] = v(1, 4'b0001, 32'hA1,       4'b0, 1, 0, 0, 32'h0,        0, 4'hF, 0, 1);
    tbl[18] = v(1, 4'b0001, 32'hA2,       4'b0001, 1, 1, 0, 32'hA1,    0, 4'hF, 0, 1);
    tbl[19] = v(1, 4'b0000, 32'h0,        4'b0, 1, 1, 0, 32'hA2,       1, 4'hF, 1, 1);
    tbl[20] = v(1, 4'b0000, 32'h0,        4'b0, 1, 1, 1, 32'hA0,       1, 4'hF, 1, 0);
    tbl[21] = v(1, 4'b0000, 32'h0,        4'b0, 1, 0, 0, 32'h0,        0, 4'hF, 1, 0);

    idle_inputs();
    #3;
    do_reset_check();

    // Directed table.
    for (int i = 0; i < 22; i++) begin
      int m;
      idle_inputs();
      m = tbl[i].inst;
      in_vld[m]  = tbl[i].vld;
      for (int c = 0; c < 4; c++) in_dat[m][c] = tbl[i].dat;
      in_last[m] = tbl[i].last;
      out_rdy[m] = tbl[i].rdy;
      tick();
      chk("tbl_vld", i, out_vld[m], tbl[i].e_vld);
      if (tbl[i].e_vld) begin
        chk("tbl_ch", i, out_ch[m], tbl[i].e_ch);
        chk("tbl_dat", i, out_dat[m], tbl[i].e_dat);
        chk("tbl_last", i, out_last[m], tbl[i].e_last);
      end
      chk("tbl_in_rdy", i, in_rdy[m], tbl[i].e_in_rdy);
      chk("tbl_occ", i, occ[m][tbl[i].occ_ch], tbl[i].e_occ);
    end

    // Mid-stream reset: buffered beats are discarded.
    idle_inputs();
    out_rdy[0] = 1'b0;
    for (int j = 0; j < 2; j++) begin
      in_vld[0] = 4'hF; in_vld[1] = 4'hF;
      for (int c = 0; c < 4; c++) begin
        in_dat[0][c] = 32'h900 + j; in_dat[1][c] = 32'h900 + j;
      end
      tick();
    end
    idle_inputs();
    do_reset_check();

    // RR fairness: every channel holds 4 beats, then drain with out_rdy=1.
    out_rdy[0] = 1'b0;
    for (int j = 0; j < 4; j++) begin
      in_vld[0] = 4'hF;
      for (int c = 0; c < 4; c++) in_dat[0][c] = 32'h100 * c + j;
      tick();
      if (j == 1) begin
        chk("first_gnt_vld", 0, out_vld[0], 1);
        chk("first_gnt_ch", 0, out_ch[0], 0);
      end
    end
    idle_inputs();
    for (int k = 0; k < 16; k++) begin
      chk("rr_vld", k, out_vld[0], 1);
      chk("rr_ch", k, out_ch[0], k % 4);
      chk("rr_dat", k, out_dat[0], 32'h100 * (k % 4) + k / 4);
      tick();
    end
    chk("rr_drained", 0, out_vld[0], 0);

    // Random stress against the model, with a reset in the middle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) do_reset_check();
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < 4; c++) begin
          in_vld[m][c]  = ($urandom_range(0, 1) == 1);
          in_dat[m][c]  = $urandom;
          in_last[m][c] = ($urandom_range(0, 3) == 0);
        end
        out_rdy[m] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int m = 0; m < 2; m++) out_rdy[m] = ~out_rdy[m];
      #1;
      for (int m = 0; m < 2; m++) begin
        chk("rdy_indep", m, in_rdy[m], model_rdy(m));
        out_rdy[m] = ~out_rdy[m];
      end
      tick();
    end

    // Final reset with data still in flight.
    do_reset_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
